// File: rtl/axi4_stream_slave_rx.sv
// AXI4-Stream receive stage: beats go to the data FIFO as {keep_code, tdata}, one descriptor per packet.
// Optional statistics counters are built when AXIS_RX_STATS_EN is defined.
module axi4_stream_slave_rx #(
  parameter int DATABUSWIDTH  = 16,
  parameter int TDESTWIDTH    = 2,
  parameter int FIFODATAWIDTH = 132,
  parameter int DESCWIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [DATABUSWIDTH*8-1:0]  s_axis_tdata,
  input  logic [DATABUSWIDTH-1:0]    s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic [TDESTWIDTH-1:0]      s_axis_tdest,
  output logic [FIFODATAWIDTH-1:0]   fifo1_din,
  output logic                       fifo1_wr_en,
  input  logic                       fifo1_full_flag,
  input  logic                       fifo1_prog_full_flag,
  output logic [DESCWIDTH-1:0]       desc_din,
  output logic                       desc_wr_en,
  input  logic                       desc_full_flag,
  output logic [15:0]                pkt_count,
  output logic [15:0]                err_count
);

  typedef enum logic [1:0] {IDLE, RECV, CLOSE} state_t;

  localparam logic [10:0] LEN_LIMIT = 11'd1024;

  state_t                  state;
  logic [10:0]             len_q;
  logic [TDESTWIDTH-1:0]   dest_q;
  logic                    first_q;
  logic                    err_q;
  logic                    wr_q;

  logic                    accept;
  logic                    wr_err;
  logic [3:0]              code;
  logic [2:0]              inc;
  logic                    keep_err;
  logic                    dest_err;
  logic [10:0]             len_base;
  logic [10:0]             len_sum;
  logic                    over;

  // tready has no path from tvalid: only state and the downstream flags.
  assign s_axis_tready = (state == RECV) & ~fifo1_prog_full_flag & ~desc_full_flag;
  assign accept        = s_axis_tvalid & s_axis_tready;

  // The pending write is squashed by a full data FIFO in the write cycle itself.
  assign fifo1_wr_en = wr_q & ~fifo1_full_flag;
  assign wr_err      = wr_q & fifo1_full_flag;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    code     = 4'b1111;
    inc      = 3'd4;
    keep_err = 1'b0;
    if (s_axis_tkeep == 16'h00FF) begin
      code     = 4'b0011;
      inc      = 3'd2;
      keep_err = ~s_axis_tlast;
    end else if (s_axis_tkeep != 16'hFFFF) begin
      keep_err = 1'b1;
    end
    len_base = first_q ? 11'd0 : len_q;
    len_sum  = len_base + {8'd0, inc};
    over     = (len_sum > LEN_LIMIT);
    dest_err = ~first_q & (s_axis_tdest != dest_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      dest_q     <= '0;
      first_q    <= 1'b1;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
      fifo1_din  <= '0;
      desc_wr_en <= 1'b0;
      desc_din   <= '0;
    end else begin
      wr_q       <= 1'b0;
      desc_wr_en <= 1'b0;
      if (wr_err) err_q <= 1'b1;

      case (state)
        IDLE: state <= RECV;

        RECV: begin
          if (accept) begin
            first_q <= 1'b0;
            if (first_q) dest_q <= s_axis_tdest;
            // A beat past the 1024-dword limit is taken off the bus but never written.
            if (!over) begin
              len_q     <= len_sum;
              wr_q      <= 1'b1;
              fifo1_din <= {code, s_axis_tdata};
            end
            if (keep_err | dest_err | over) err_q <= 1'b1;
            if (s_axis_tlast) state <= CLOSE;
          end
        end

        CLOSE: begin
          // The last beat's write happens this cycle, so its full-flag error is folded in here.
          desc_wr_en <= 1'b1;
          desc_din   <= {err_q | wr_err, 2'b00, dest_q[1], 1'b0, dest_q[0], len_q[9:0]};
          err_q      <= 1'b0;
          first_q    <= 1'b1;
          state      <= RECV;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_RX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (desc_wr_en) begin
      pkt_count <= pkt_count + 16'd1;
      if (desc_din[DESCWIDTH-1]) err_count <= err_count + 16'd1;
    end
  end
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_axi4_stream_slave_rx.sv
// Self-checking bench for axi4_stream_slave_rx: vector table, directed corner cases and
// randomized packets scored against a packet-level reference model.
module tb_axi4_stream_slave_rx;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [127:0] s_axis_tdata;
  logic [15:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic [1:0]   s_axis_tdest;
  logic [131:0] fifo1_din;
  logic         fifo1_wr_en;
  logic         fifo1_full_flag;
  logic         fifo1_prog_full_flag;
  logic [15:0]  desc_din;
  logic         desc_wr_en;
  logic         desc_full_flag;
  logic [15:0]  pkt_count;
  logic [15:0]  err_count;

  axi4_stream_slave_rx dut (
    .clk                  (clk),
    .reset                (reset),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tdest         (s_axis_tdest),
    .fifo1_din            (fifo1_din),
    .fifo1_wr_en          (fifo1_wr_en),
    .fifo1_full_flag      (fifo1_full_flag),
    .fifo1_prog_full_flag (fifo1_prog_full_flag),
    .desc_din             (desc_din),
    .desc_wr_en           (desc_wr_en),
    .desc_full_flag       (desc_full_flag),
    .pkt_count            (pkt_count),
    .err_count            (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  keep;
    logic [1:0]   dest;
    logic [127:0] data;
  } beat_t;

  typedef struct {
    int          nb;
    logic [15:0] k0;
    logic [15:0] k1;
    logic [1:0]  d0;
    logic [1:0]  d1;
    logic [15:0] desc;
    logic [3:0]  c0;
    logic [3:0]  c1;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  int           exp_pkt = 0;
  int           exp_err = 0;
  bit           done;
  beat_t        pkt[$];
  logic [131:0] got_wr[$];
  logic [15:0]  got_desc[$];
  logic [131:0] exp_wr[$];
  logic [15:0]  exp_desc;

  // Outputs are observed on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (fifo1_wr_en === 1'b1) got_wr.push_back(fifo1_din);
    if (desc_wr_en === 1'b1) got_desc.push_back(desc_din);
  end

  task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [3:0] wr_code(input int idx);
    if (got_wr.size() > idx) return got_wr[idx][131:128];
    return 4'bx;
  endfunction

  function automatic logic [15:0] desc_at(input int idx);
    if (got_desc.size() > idx) return got_desc[idx];
    return 16'bx;
  endfunction

  // Packet-level model: walk the beats, sum dwords, collect the error causes.
  task automatic model_pkt(input bit full_all);
    int         len;
    int         inc;
    bit         err;
    logic [3:0] code;
    logic [1:0] d;
    len = 0;
    err = full_all;
    d   = pkt[0].dest;
    exp_wr.delete();
    foreach (pkt[i]) begin
      if (pkt[i].keep == 16'hFFFF) begin
        code = 4'hF; inc = 4;
      end else if (pkt[i].keep == 16'h00FF) begin
        code = 4'h3; inc = 2;
        if (i != pkt.size() - 1) err = 1;
      end else begin
        code = 4'hF; inc = 4; err = 1;
      end
      if (pkt[i].dest != d) err = 1;
      if (len + inc > 1024) err = 1;
      else begin
        len += inc;
        if (!full_all) exp_wr.push_back({code, pkt[i].data});
      end
    end
    exp_desc = {err, 2'b00, d[1], 1'b0, d[0], 10'(len % 1024)};
  endtask

  task automatic send_beat(input beat_t b, input bit last);
    int t;
    bit ok;
    t  = 0;
    ok = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tdest  = b.dest;
    s_axis_tlast  = last;
    while (!ok) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      t++;
      if (!ok && t > 3000) begin
        check("beat_accept_timeout", 1, 0);
        ok = 1;
      end
    end
  endtask

  task automatic run_pkt(input string name, input int gap_max, input bit full_all, input bit chk_close);
    int wr_base;
    int desc_base;
    int t;
    int bad;
    model_pkt(full_all);
    wr_base   = got_wr.size();
    desc_base = got_desc.size();
    foreach (pkt[i]) begin
      int gap;
      gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (gap > 0) begin
        s_axis_tvalid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      send_beat(pkt[i], i == pkt.size() - 1);
    end
    s_axis_tvalid = 1'b0;
    if (chk_close) begin
      @(negedge clk);
      check({name, " close_tready"}, s_axis_tready, 0);
      check({name, " close_desc_wr"}, desc_wr_en, 0);
      @(negedge clk);
      check({name, " reopen_tready"}, s_axis_tready, 1);
      check({name, " desc_wr_pulse"}, desc_wr_en, 1);
    end
    t = 0;
    while (got_desc.size() <= desc_base && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    @(negedge clk);
    check({name, " nwr"}, got_wr.size() - wr_base, exp_wr.size());
    bad = -1;
    foreach (exp_wr[i]) begin
      if (bad < 0 && (wr_base + i >= got_wr.size() || got_wr[wr_base + i] !== exp_wr[i])) bad = i;
    end
    check({name, " first_bad_word"}, bad, -1);
    check({name, " ndesc"}, got_desc.size() - desc_base, 1);
    check({name, " desc"}, desc_at(desc_base), exp_desc);
    exp_pkt++;
    if (exp_desc[15]) exp_err++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[7];
    int   base;
    int   dbase;
    int   hi;

    vecs[0] = '{1, 16'hFFFF, 16'hFFFF, 2'd0, 2'd0, 16'h0004, 4'hF, 4'hF};
    vecs[1] = '{1, 16'h00FF, 16'hFFFF, 2'd3, 2'd3, 16'h1402, 4'h3, 4'hF};
    vecs[2] = '{1, 16'h000F, 16'hFFFF, 2'd1, 2'd1, 16'h8404, 4'hF, 4'hF};
    vecs[3] = '{2, 16'hFFFF, 16'hFFFF, 2'd2, 2'd2, 16'h1008, 4'hF, 4'hF};
    vecs[4] = '{2, 16'h00FF, 16'hFFFF, 2'd0, 2'd0, 16'h8006, 4'h3, 4'hF};
    vecs[5] = '{2, 16'h000F, 16'hFFFF, 2'd1, 2'd2, 16'h8408, 4'hF, 4'hF};
    vecs[6] = '{2, 16'hFFFF, 16'h00FF, 2'd3, 2'd3, 16'h1406, 4'hF, 4'h3};

    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    s_axis_tdest = '0;
    fifo1_full_flag = 1'b0;
    fifo1_prog_full_flag = 1'b0;
    desc_full_flag = 1'b0;

    // Reset values, then one IDLE cycle before tready rises.
    repeat (3) @(posedge clk);
    #1;
    check("rst tready", s_axis_tready, 0);
    check("rst fifo1_wr_en", fifo1_wr_en, 0);
    check("rst desc_wr_en", desc_wr_en, 0);
    check("rst fifo1_din", fifo1_din, 0);
    check("rst desc_din", desc_din, 0);
    check("rst pkt_count", pkt_count, 0);
    check("rst err_count", err_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle tready", s_axis_tready, 0);
    @(negedge clk);
    check("recv tready", s_axis_tready, 1);
    @(posedge clk);
    #1;

    // Vector table: short packets with hand-computed descriptors and keep codes.
    for (int v = 0; v < 7; v++) begin
      pkt.delete();
      pkt.push_back('{vecs[v].k0, vecs[v].d0, rand_data()});
      if (vecs[v].nb == 2) pkt.push_back('{vecs[v].k1, vecs[v].d1, rand_data()});
      base  = got_wr.size();
      dbase = got_desc.size();
      run_pkt($sformatf("vec%0d", v), 0, 0, 0);
      check($sformatf("vec%0d desc_const", v), desc_at(dbase), vecs[v].desc);
      check($sformatf("vec%0d code0", v), wr_code(base), vecs[v].c0);
      if (vecs[v].nb == 2) check($sformatf("vec%0d code1", v), wr_code(base + 1), vecs[v].c1);
    end

    // 256 dwords, dest 01.
    pkt.delete();
    for (int i = 0; i < 64; i++) pkt.push_back('{16'hFFFF, 2'd1, rand_data()});
    base = got_wr.size(); dbase = got_desc.size();
    run_pkt("p256", 1, 0, 0);
    check("p256 desc_const", desc_at(dbase), 16'h0500);
    check("p256 nwr_const", got_wr.size() - base, 64);

    // Three beats ending in a half beat, with close-cycle timing.
    pkt.delete();
    pkt.push_back('{16'hFFFF, 2'd2, rand_data()});
    pkt.push_back('{16'hFFFF, 2'd2, rand_data()});
    pkt.push_back('{16'h00FF, 2'd2, rand_data()});
    base = got_wr.size(); dbase = got_desc.size();
    run_pkt("p3", 0, 0, 1);
    check("p3 desc_const", desc_at(dbase), 16'h100A);
    check("p3 code2", wr_code(base + 2), 4'h3);

    // Overflow: 257 full beats, last one dropped but still closes.
    pkt.delete();
    for (int i = 0; i < 257; i++) pkt.push_back('{16'hFFFF, 2'd0, rand_data()});
    base = got_wr.size(); dbase = got_desc.size();
    run_pkt("ovf", 0, 0, 0);
    check("ovf desc_const", desc_at(dbase), 16'h8000);
    check("ovf nwr_const", got_wr.size() - base, 256);

    // 1022 dwords fits; 1024 + half beat overflows.
    pkt.delete();
    for (int i = 0; i < 255; i++) pkt.push_back('{16'hFFFF, 2'd0, rand_data()});
    pkt.push_back('{16'h00FF, 2'd0, rand_data()});
    dbase = got_desc.size();
    run_pkt("len1022", 0, 0, 0);
    check("len1022 desc_const", desc_at(dbase), 16'h03FE);
    pkt.delete();
    for (int i = 0; i < 256; i++) pkt.push_back('{16'hFFFF, 2'd0, rand_data()});
    pkt.push_back('{16'h00FF, 2'd0, rand_data()});
    dbase = got_desc.size();
    run_pkt("len1026", 0, 0, 0);
    check("len1026 desc_const", desc_at(dbase), 16'h8000);

    // Data FIFO full: the write is dropped and the packet is flagged.
    fifo1_full_flag = 1'b1;
    pkt.delete();
    pkt.push_back('{16'hFFFF, 2'd0, rand_data()});
    dbase = got_desc.size();
    run_pkt("full", 0, 1, 0);
    check("full desc_const", desc_at(dbase), 16'h8004);
    fifo1_full_flag = 1'b0;

    // Programmable-full stall for 10 cycles mid-packet.
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back('{16'hFFFF, 2'd0, rand_data()});
    dbase = got_desc.size();
    hi = 0;
    fork
      run_pkt("pf", 0, 0, 0);
      begin
        repeat (6) @(posedge clk);
        #1;
        fifo1_prog_full_flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (s_axis_tready) hi++;
        end
        @(posedge clk);
        #1;
        fifo1_prog_full_flag = 1'b0;
      end
    join
    check("pf tready_high_cycles", hi, 0);
    check("pf desc_const", desc_at(dbase), 16'h0050);

    // Reset after beat 5 of 10: strobes drop at once, no descriptor.
    base = got_wr.size(); dbase = got_desc.size();
    for (int i = 0; i < 5; i++) send_beat('{16'hFFFF, 2'd1, rand_data()}, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check("midrst tready", s_axis_tready, 0);
    check("midrst fifo1_wr_en", fifo1_wr_en, 0);
    check("midrst desc_wr_en", desc_wr_en, 0);
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst nwr", got_wr.size() - base, 4);
    check("midrst ndesc", got_desc.size() - dbase, 0);
    pkt.delete();
    for (int i = 0; i < 3; i++) pkt.push_back('{16'hFFFF, 2'd0, rand_data()});
    dbase = got_desc.size();
    run_pkt("postrst", 0, 0, 0);
    check("postrst desc_const", desc_at(dbase), 16'h000C);

    // Randomized packets with random back-pressure against the model.
    done = 0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int         n;
          int         r;
          logic [1:0] d;
          logic [15:0] k;
          logic [1:0]  bd;
          n = $urandom_range(1, 24);
          if ($urandom_range(0, 19) == 0) n = $urandom_range(250, 262);
          d = 2'($urandom_range(0, 3));
          pkt.delete();
          for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (i == n - 1 && r < 40) k = 16'h00FF;
            else if (r < 80) k = 16'hFFFF;
            else if (r < 90) k = 16'h00FF;
            else if (r < 95) k = 16'($urandom());
            else k = 16'hFFFF;
            bd = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3)) : d;
            pkt.push_back('{k, bd, rand_data()});
          end
          run_pkt($sformatf("rnd%0d", p), 2, 0, 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          fifo1_prog_full_flag = ($urandom_range(0, 3) == 0);
          desc_full_flag       = ($urandom_range(0, 7) == 0);
        end
        fifo1_prog_full_flag = 1'b0;
        desc_full_flag       = 1'b0;
      end
    join

    repeat (3) @(posedge clk);
    #1;
`ifdef AXIS_RX_STATS_EN
    check("stats pkt_count", pkt_count, 16'(exp_pkt));
    check("stats err_count", err_count, 16'(exp_err));
`else
    check("stats pkt_count", pkt_count, 0);
    check("stats err_count", err_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
